// File: rtl/clock_mgr_pkg.sv
// Shared types and helpers for the multi-channel frequency counter.
// State encoding, result width and the saturating scale multiply.
package clock_mgr_pkg;

  localparam int FREQ_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    LATCH
  } state_e;

  // Wide product so any count/scale pair clamps instead of wrapping.
  function automatic logic [FREQ_W-1:0] sat_mul(
    input logic [FREQ_W-1:0] cnt,
    input logic [63:0]       scale
  );
    logic [95:0] prod;
    prod = {64'd0, cnt} * {32'd0, scale};
    return (|prod[95:FREQ_W]) ? '1 : prod[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/clock_mgr_freq_chan.sv
// One measured clock: divide, toggle, resynchronise into clk.
// Emits a single-cycle pulse in clk for every flag transition.
module clock_mgr_freq_chan #(
  parameter int CLK_DIVISOR = 1000,
  parameter int SYNC_STAGES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_clk,
  output logic edge_o
);

  localparam int DW = $clog2(CLK_DIVISOR);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIVISOR - 1);

  logic [DW-1:0] div_q, div_d;
  logic          flag_q, flag_d;

  always_comb begin
    div_d  = div_q - DW'(1);
    flag_d = flag_q;
    if (div_q == '0) begin
      div_d  = RELOAD;
      flag_d = ~flag_q;
    end
  end

  // Free-running in the test domain; phase is irrelevant to the count.
  always_ff @(posedge test_clk) begin
    div_q  <= div_d;
    flag_q <= flag_d;
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prior_q, prior_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], flag_q};
    prior_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prior_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prior_q <= prior_d;
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] ^ prior_q;

endmodule

// File: rtl/clock_mgr_freq_ctr_multi.sv
// Shared gate window over NUM_CH edge counters.
// Scales each count to Hz and flags channels that saw no edges.
module clock_mgr_freq_ctr_multi
  import clock_mgr_pkg::*;
#(
  parameter int    FREQ_HZ     = 250000000,
  parameter int    NUM_CH      = 4,
  parameter int    CLK_DIVISOR = 1000,
  parameter int    GATE_DIV    = 10,
  parameter int    SYNC_STAGES = 4,
  parameter int    CNT_W       = 24,
  parameter longint MAX_TEST_HZ = 64'd1000000000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_CH-1:0]        test_clk,
  input  logic                     enable,
  output logic [FREQ_W*NUM_CH-1:0] freq_out,
  output logic [NUM_CH-1:0]        stopped,
  output logic                     valid,
  output logic                     busy
);

  localparam int GATE_RAW = FREQ_HZ / GATE_DIV;
  localparam int GATE_CYC = (GATE_RAW < 2) ? 2 : GATE_RAW;
  localparam int GW       = $clog2(GATE_CYC);
  localparam logic [GW-1:0] GATE_LD = GW'(GATE_CYC - 1);
  localparam logic [63:0]   SCALE   =
    64'(CLK_DIVISOR) * 64'(GATE_DIV);

  if (GATE_RAW < 2) begin : g_bad_gate
    $error("gate window shorter than two clk cycles");
  end

  if (MAX_TEST_HZ > longint'(FREQ_HZ) * CLK_DIVISOR / 4)
  begin : g_bad_rate
    $error("test clock too fast for CLK_DIVISOR");
  end

  if (NUM_CH < 1 || NUM_CH > 16 || SYNC_STAGES < 2 ||
      SYNC_STAGES > 8 || CLK_DIVISOR < 2) begin : g_bad_par
    $error("parameter out of range");
  end

  logic [NUM_CH-1:0] edge_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clock_mgr_freq_chan #(
      .CLK_DIVISOR (CLK_DIVISOR),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (resetn),
      .test_clk (test_clk[g]),
      .edge_o   (edge_w[g])
    );
  end

  state_e            state_q, state_d;
  logic [GW-1:0]     gate_q, gate_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [FREQ_W-1:0] freq_q [NUM_CH];
  logic [FREQ_W-1:0] freq_d [NUM_CH];
  logic [NUM_CH-1:0] stopped_q, stopped_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              discard_q, discard_d;

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    cnt_d     = cnt_q;
    freq_d    = freq_q;
    stopped_d = stopped_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    discard_d = discard_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = GATE;
          gate_d    = GATE_LD;
          busy_d    = 1'b1;
          discard_d = 1'b1;
          for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
        end
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (edge_w[i] && cnt_q[i] != '1)
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          if (gate_q == '0) state_d = LATCH;
          else              gate_d  = gate_q - GW'(1);
        end
      end
      LATCH: begin
        // Settling window: results are dropped, outputs keep old values.
        if (!discard_q) begin
          for (int i = 0; i < NUM_CH; i++) begin
            freq_d[i]    = sat_mul(FREQ_W'(cnt_q[i]), SCALE);
            stopped_d[i] = (cnt_q[i] == '0);
          end
          valid_d = 1'b1;
        end
        discard_d = 1'b0;
        if (enable) begin
          state_d = GATE;
          gate_d  = GATE_LD;
          for (int i = 0; i < NUM_CH; i++)
            cnt_d[i] = CNT_W'(edge_w[i]);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      stopped_q <= '1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      discard_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        freq_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      stopped_q <= stopped_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      discard_q <= discard_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        freq_q[i] <= freq_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign freq_out[FREQ_W*g +: FREQ_W] = freq_q[g];
  end

  assign stopped = stopped_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
